// File: rtl/vdp_host_pkg.sv
// Shared types and constants for the VDP host bridge: access entry, request FSM states
// and synchroniser depth.
package vdp_host_pkg;

    localparam int unsigned HB_ADDR_W  = 2;
    localparam int unsigned HB_DATA_W  = 8;
    localparam int unsigned SYNC_DEPTH = 2;

    // Queued host access as seen at the default bus widths.
    typedef struct packed {
        logic                 wr;
        logic [HB_ADDR_W-1:0] adr;
        logic [HB_DATA_W-1:0] data;
    } host_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } host_state_e;

endpackage

// File: rtl/host_pin_filter.sv
// Synchroniser plus run-length deglitch filter for one asynchronous, active-low host strobe.
// The filtered output changes only after FILTER_LEN consecutive equal synchronised samples.
module host_pin_filter
    import vdp_host_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt
);

    localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [RUN_W-1:0]      run_q;
    logic                  sample;

    assign sample = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            run_q  <= '0;
            filt   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pin};
            if (sample == filt) begin
                run_q <= '0;
            end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
                // This sample completes the run of FILTER_LEN differing samples.
                filt  <= sample;
                run_q <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdp_host_bridge.sv
// Host bus front end: deglitched strobes queue accesses in a FIFO that drives the VDP via REQ/ACK.
// Optional ack timeout enabled by defining HOST_BRIDGE_TIMEOUT_EN.
module vdp_host_bridge
    import vdp_host_pkg::*;
#(
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned FILTER_LEN     = 3,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mode,
    input  logic              csr_n,
    input  logic              csw_n,
    input  logic [DATA_W-1:0] cd_in,
    output logic [DATA_W-1:0] cd_out,
    output logic              cd_oe,
    output logic              vdp_req,
    output logic              vdp_wrt,
    output logic [ADDR_W-1:0] vdp_adr,
    output logic [DATA_W-1:0] vdp_dbo,
    input  logic              vdp_ack,
    input  logic [DATA_W-1:0] vdp_dbi,
    output logic              busy,
    output logic              overflow,
    output logic              timeout
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic rd_filt, wr_filt, rd_filt_q, wr_filt_q;

    host_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (csr_n),
        .filt  (rd_filt)
    );

    host_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (csw_n),
        .filt  (wr_filt)
    );

    // mode/cd_in delayed to line up with the filtered strobe edge.
    logic [ADDR_W-1:0] mode_dly [SYNC_DEPTH];
    logic [DATA_W-1:0] cd_dly   [SYNC_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_DEPTH); i++) begin
                mode_dly[i] <= '0;
                cd_dly[i]   <= '0;
            end
            rd_filt_q <= 1'b1;
            wr_filt_q <= 1'b1;
            cd_oe     <= 1'b0;
        end else begin
            mode_dly[0] <= mode;
            cd_dly[0]   <= cd_in;
            for (int i = 1; i < int'(SYNC_DEPTH); i++) begin
                mode_dly[i] <= mode_dly[i-1];
                cd_dly[i]   <= cd_dly[i-1];
            end
            rd_filt_q <= rd_filt;
            wr_filt_q <= wr_filt;
            cd_oe     <= ~rd_filt;
        end
    end

    logic rd_fall, wr_fall, push_req, push_ok, pop, full, empty;

    assign rd_fall  = rd_filt_q & ~rd_filt;
    assign wr_fall  = wr_filt_q & ~wr_filt;
    // Simultaneous falls are ambiguous and are discarded.
    assign push_req = rd_fall ^ wr_fall;

    logic              fifo_wr  [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_adr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_dat [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_wr[wr_ptr_q]  <= wr_fall;
            fifo_adr[wr_ptr_q] <= mode_dly[SYNC_DEPTH-1];
            fifo_dat[wr_ptr_q] <= cd_dly[SYNC_DEPTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
            if (push_req && !push_ok) overflow <= 1'b1;
        end
    end

    host_state_e state_q, state_d;
    logic        issue, tmo_fire;

`ifdef HOST_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit;
    logic             timeout_q;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == REQ && !pop) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                        tmo_cnt_q <= '0;
            if (tmo_fire) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        pop      = 1'b0;
        tmo_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    issue   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (vdp_ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
`ifdef HOST_BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    pop      = 1'b1;
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vdp_req <= 1'b0;
            vdp_wrt <= 1'b0;
            vdp_adr <= '0;
            vdp_dbo <= '0;
            cd_out  <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                vdp_req <= 1'b1;
                vdp_wrt <= fifo_wr[rd_ptr_q];
                vdp_adr <= fifo_adr[rd_ptr_q];
                vdp_dbo <= fifo_dat[rd_ptr_q];
            end else if (pop) begin
                vdp_req <= 1'b0;
            end
            // A timed-out read returns all-ones to the host.
            if (pop && !vdp_wrt) cd_out <= tmo_fire ? '1 : vdp_dbi;
        end
    end

    assign busy = ~empty | vdp_req;

endmodule

// File: tb/tb_vdp_host_bridge.sv
// Directed self-checking bench for vdp_host_bridge: table of single accesses plus
// hand-written ordering, overflow, collision, reset and (optional) timeout sequences.
module tb_vdp_host_bridge;

    localparam int unsigned ADDR_W         = 2;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned FILTER_LEN     = 3;
    localparam int unsigned FIFO_DEPTH     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] mode;
    logic              csr_n, csw_n;
    logic [DATA_W-1:0] cd_in, cd_out;
    logic              cd_oe;
    logic              vdp_req, vdp_wrt;
    logic [ADDR_W-1:0] vdp_adr;
    logic [DATA_W-1:0] vdp_dbo, vdp_dbi;
    logic              vdp_ack;
    logic              busy, overflow, timeout;

    vdp_host_bridge #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .FILTER_LEN     (FILTER_LEN),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .csr_n    (csr_n),
        .csw_n    (csw_n),
        .cd_in    (cd_in),
        .cd_out   (cd_out),
        .cd_oe    (cd_oe),
        .vdp_req  (vdp_req),
        .vdp_wrt  (vdp_wrt),
        .vdp_adr  (vdp_adr),
        .vdp_dbo  (vdp_dbo),
        .vdp_ack  (vdp_ack),
        .vdp_dbi  (vdp_dbi),
        .busy     (busy),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit         wr;
        logic [1:0] mode;
        logic [7:0] data;
        int         ack_dly;
        logic [7:0] dbi;
        logic [7:0] exp_cd_out;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},  32'(vdp_req),  0);
        chk({tag, "_wrt"},  32'(vdp_wrt),  0);
        chk({tag, "_adr"},  32'(vdp_adr),  0);
        chk({tag, "_dbo"},  32'(vdp_dbo),  0);
        chk({tag, "_cdo"},  32'(cd_out),   0);
        chk({tag, "_oe"},   32'(cd_oe),    0);
        chk({tag, "_busy"}, 32'(busy),     0);
        chk({tag, "_ovf"},  32'(overflow), 0);
        chk({tag, "_tmo"},  32'(timeout),  0);
    endtask

    // Wait (bounded) for a request, check its fields, ack after dly cycles.
    task automatic serve(input string tag, input int dly, input logic [7:0] dbi,
                         input bit exp_wr, input logic [1:0] exp_adr, input logic [7:0] exp_dbo);
        int n = 0;
        while (!vdp_req && n < 80) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(vdp_req), 1);
        chk({tag, "_wrt"}, 32'(vdp_wrt), 32'(exp_wr));
        chk({tag, "_adr"}, 32'(vdp_adr), 32'(exp_adr));
        if (exp_wr) chk({tag, "_dbo"}, 32'(vdp_dbo), 32'(exp_dbo));
        repeat (dly) tick();
        if (dly > 0) chk({tag, "_hold"}, 32'(vdp_req), 1);
        vdp_ack = 1'b1;
        vdp_dbi = dbi;
        tick();
        vdp_ack = 1'b0;
        chk({tag, "_drop"}, 32'(vdp_req), 0);
    endtask

    task automatic host_access(input bit wr, input logic [1:0] m, input logic [7:0] d);
        mode  = m;
        cd_in = d;
        if (wr) csw_n = 1'b0;
        else    csr_n = 1'b0;
        repeat (FILTER_LEN + 4) tick();
        csw_n = 1'b1;
        csr_n = 1'b1;
        repeat (FILTER_LEN + 3) tick();
    endtask

    initial begin
        int  n;
        bit  seen;

        vecs[0] = '{wr: 1, mode: 2'd1, data: 8'h5A, ack_dly: 2, dbi: 8'h00, exp_cd_out: 8'h00};
        vecs[1] = '{wr: 0, mode: 2'd2, data: 8'h00, ack_dly: 0, dbi: 8'h3C, exp_cd_out: 8'h3C};
        vecs[2] = '{wr: 1, mode: 2'd3, data: 8'hFF, ack_dly: 1, dbi: 8'h77, exp_cd_out: 8'h3C};
        vecs[3] = '{wr: 0, mode: 2'd0, data: 8'h00, ack_dly: 3, dbi: 8'h96, exp_cd_out: 8'h96};
        vecs[4] = '{wr: 1, mode: 2'd0, data: 8'h00, ack_dly: 0, dbi: 8'hE1, exp_cd_out: 8'h96};

        reset   = 1'b1;
        mode    = '0;
        csr_n   = 1'b1;
        csw_n   = 1'b1;
        cd_in   = '0;
        vdp_ack = 1'b0;
        vdp_dbi = '0;
        #1;
        chk_reset_vals("rst");
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Single accesses: latency, fields, ack handshake, read data return.
        for (int i = 0; i < 5; i++) begin
            string tag;
            tag   = $sformatf("v%0d", i);
            mode  = vecs[i].mode;
            cd_in = vecs[i].data;
            if (vecs[i].wr) csw_n = 1'b0;
            else            csr_n = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (!vdp_req && n < 60);
            chk({tag, "_lat"}, 32'(n), 32'(FILTER_LEN + 4));
            chk({tag, "_oe"}, 32'(cd_oe), 32'(!vecs[i].wr));
            serve(tag, vecs[i].ack_dly, vecs[i].dbi, vecs[i].wr, vecs[i].mode, vecs[i].data);
            chk({tag, "_cdo"}, 32'(cd_out), 32'(vecs[i].exp_cd_out));
            csw_n = 1'b1;
            csr_n = 1'b1;
            repeat (10) tick();
            chk({tag, "_idle"}, 32'(busy), 0);
        end

        // Glitch shorter than the filter length.
        csw_n = 1'b0;
        repeat (FILTER_LEN - 1) tick();
        csw_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (busy) seen = 1'b1;
        end
        chk("glitch_busy", 32'(seen), 0);

        // Ordering: two writes then a read, all queued before any ack.
        host_access(1'b1, 2'd0, 8'hA0);
        host_access(1'b1, 2'd1, 8'hA1);
        host_access(1'b0, 2'd2, 8'h00);
        serve("ord0", 5, 8'h11, 1'b1, 2'd0, 8'hA0);
        chk("ord0_cdo", 32'(cd_out), 32'h96);
        serve("ord1", 5, 8'h22, 1'b1, 2'd1, 8'hA1);
        chk("ord1_cdo", 32'(cd_out), 32'h96);
        serve("ord2", 5, 8'hC3, 1'b0, 2'd2, 8'h00);
        chk("ord2_cdo", 32'(cd_out), 32'hC3);

        // Overflow: FIFO_DEPTH+1 writes while ack is held low.
        for (int i = 0; i < int'(FIFO_DEPTH); i++) host_access(1'b1, 2'(i), 8'(8'h10 + i));
        chk("ovf_before", 32'(overflow), 0);
        host_access(1'b1, 2'd3, 8'h99);
        chk("ovf_set", 32'(overflow), 1);
        for (int i = 0; i < int'(FIFO_DEPTH); i++)
            serve($sformatf("ovf%0d", i), 0, 8'h00, 1'b1, 2'(i), 8'(8'h10 + i));
        repeat (3) tick();
        chk("ovf_drained", 32'(busy), 0);
        chk("ovf_sticky", 32'(overflow), 1);

`ifdef HOST_BRIDGE_TIMEOUT_EN
        mode  = 2'd1;
        csr_n = 1'b0;
        n = 0;
        while (!vdp_req && n < 60) begin
            tick();
            n++;
        end
        chk("tmo_req", 32'(vdp_req), 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (vdp_req && n < int'(TIMEOUT_CYCLES) + 20);
        chk("tmo_len", 32'(n), 32'(TIMEOUT_CYCLES));
        chk("tmo_flag", 32'(timeout), 1);
        chk("tmo_cdo", 32'(cd_out), 32'hFF);
        csr_n = 1'b1;
        repeat (10) tick();
`else
        chk("tmo_tied", 32'(timeout), 0);
`endif

        // Collision: both strobes fall together.
        csr_n = 1'b0;
        csw_n = 1'b0;
        seen  = 1'b0;
        repeat (15) begin
            tick();
            if (busy || vdp_req) seen = 1'b1;
        end
        chk("coll_noreq", 32'(seen), 0);
        csr_n = 1'b1;
        csw_n = 1'b1;
        repeat (10) tick();

        // Reset with a request outstanding.
        mode  = 2'd2;
        cd_in = 8'h42;
        csw_n = 1'b0;
        n = 0;
        while (!vdp_req && n < 60) begin
            tick();
            n++;
        end
        chk("rreq_up", 32'(vdp_req), 1);
        chk("rreq_ovf", 32'(overflow), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        csw_n = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            tick();
            if (vdp_req || busy) seen = 1'b1;
        end
        chk("post_rst_quiet", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
